// File: rtl/mac_job_ctrl.sv
// Job-level initiator for the 8x8 MAC: takes a dot-product command, streams operand
// pairs into the MAC, aligns enable/clear with the product pipeline, returns the sum.
module mac_job_ctrl #(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    output logic             mac_enable,
    output logic             mac_clear,
    input  logic [15:0]      mac_result,
    input  logic             mac_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic             out_overflow,
    output logic             busy
);
    // state  | meaning
    // IDLE   | waiting for a command, cmd_ready high
    // CLEAR  | one-cycle accumulator clear pulse
    // STREAM | accepting operand pairs until rem reaches zero
    // DRAIN  | PIPE_LAT+1 cycles for the last product to reach the accumulator
    // DONE   | result presented until out_ready

    localparam int DW = $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  rem, rem_nxt;
    logic [DW-1:0]     drain_cnt, drain_cnt_nxt;
    logic [PIPE_LAT-1:0] en_sr;
    logic              sticky, sticky_nxt;
    logic              fire;
    logic              capture;

    assign cmd_ready = (state == S_IDLE);
    assign in_ready  = (state == S_STREAM);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign fire      = in_valid & in_ready;
    assign mac_a     = fire ? in_a : 8'd0;
    assign mac_b     = fire ? in_b : 8'd0;
    assign mac_enable = en_sr[PIPE_LAT-1];

    always_comb begin
        state_nxt     = state;
        rem_nxt       = rem;
        drain_cnt_nxt = drain_cnt;
        sticky_nxt    = sticky;
        capture       = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    rem_nxt    = cmd_len;
                    sticky_nxt = 1'b0;
                    state_nxt  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (rem != '0) begin
                    state_nxt = S_STREAM;
                end else begin
                    drain_cnt_nxt = DW'(PIPE_LAT);
                    state_nxt     = S_DRAIN;
                end
            end
            S_STREAM: begin
                sticky_nxt = sticky | mac_overflow;
                if (fire) begin
                    rem_nxt = rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) begin
                        drain_cnt_nxt = DW'(PIPE_LAT);
                        state_nxt     = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                sticky_nxt = sticky | mac_overflow;
                if (drain_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    drain_cnt_nxt = drain_cnt - DW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            rem          <= '0;
            drain_cnt    <= '0;
            sticky       <= 1'b0;
            en_sr        <= '0;
            mac_clear    <= 1'b0;
            out_result   <= 16'd0;
            out_overflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            rem       <= rem_nxt;
            drain_cnt <= drain_cnt_nxt;
            sticky    <= sticky_nxt;
            // enable trails each fire by the product pipeline depth
            en_sr[0]  <= fire;
            for (int i = 1; i < PIPE_LAT; i++) en_sr[i] <= en_sr[i-1];
            mac_clear <= (state_nxt == S_CLEAR);
            if (capture) begin
                out_result   <= mac_result;
                out_overflow <= sticky | mac_overflow;
            end
        end
    end

endmodule

// File: tb/tb_mac_job_ctrl.sv
// Bench for mac_job_ctrl: a small MAC (multiplier -> pipeline reg -> accumulator) is
// attached, and each job is compared with the arithmetic sum of its operand products.
module tb_mac_job_ctrl;
    localparam int LEN_W    = 8;
    localparam int PIPE_LAT = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid, cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             in_valid, in_ready;
    logic [7:0]       in_a, in_b, mac_a, mac_b;
    logic             mac_enable, mac_clear;
    logic [15:0]      mac_result;
    logic             mac_overflow;
    logic             out_valid, out_ready;
    logic [15:0]      out_result;
    logic             out_overflow, busy;

    mac_job_ctrl #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_enable(mac_enable), .mac_clear(mac_clear),
        .mac_result(mac_result), .mac_overflow(mac_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // attached MAC datapath
    logic [15:0] prod, acc;
    logic        acc_ovf;
    logic [16:0] acc_sum;
    assign acc_sum      = {1'b0, acc} + {1'b0, prod};
    assign mac_result   = acc;
    assign mac_overflow = acc_ovf;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod <= 16'd0; acc <= 16'd0; acc_ovf <= 1'b0;
        end else begin
            prod <= 16'(mac_a) * 16'(mac_b);
            if (mac_clear) begin
                acc <= 16'd0; acc_ovf <= 1'b0;
            end else if (mac_enable) begin
                acc <= acc_sum[15:0]; acc_ovf <= acc_ovf | acc_sum[16];
            end
        end
    end

    // pulse monitor: enable must follow each fire by exactly one cycle
    int   en_cnt = 0, clr_cnt = 0, overlap_cnt = 0, en_err = 0;
    logic prev_fire = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_fire = 1'b0;
        end else begin
            if (mac_enable) en_cnt++;
            if (mac_clear) clr_cnt++;
            if (mac_enable && mac_clear) overlap_cnt++;
            if (mac_enable !== prev_fire) en_err++;
            prev_fire = in_valid & in_ready;
        end
    end

    int vectors = 0, miscompares = 0;

    logic [7:0]  ja [0:255];
    logic [7:0]  jb [0:255];
    int          c0, last_fire, obs_lat, obs_en, obs_clr, obs_ovl, obs_enerr;
    logic [15:0] obs_res;
    logic        obs_ovf;
    bit          obs_tmo;

    function automatic int ref_sum(input int len);
        int s = 0;
        for (int i = 0; i < len; i++) s += int'(ja[i]) * int'(jb[i]);
        return s;
    endfunction

    // drives one job from IDLE up to the first out_valid cycle; leaves out_ready low
    task automatic run_job(input int len, input int gap, input bit rand_gap);
        int e0, cl0, ov0, er0, tmo, g;
        e0 = en_cnt; cl0 = clr_cnt; ov0 = overlap_cnt; er0 = en_err;
        obs_tmo   = 1'b0;
        last_fire = -1;
        cmd_valid = 1'b1; cmd_len = LEN_W'(len); c0 = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_len = LEN_W'($urandom);
        for (int i = 0; i < len; i++) begin
            g = rand_gap ? int'($urandom_range(gap, 0)) : gap;
            repeat (g) begin
                in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1; in_a = ja[i]; in_b = jb[i];
            tmo = 0;
            while (!in_ready && tmo < 20) begin @(posedge clk); #1; tmo++; end
            if (tmo >= 20) obs_tmo = 1'b1;
            last_fire = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tmo = 0;
        while (!out_valid && tmo < 60) begin @(posedge clk); #1; tmo++; end
        if (tmo >= 60) obs_tmo = 1'b1;
        obs_lat   = cyc - c0;
        obs_res   = out_result;
        obs_ovf   = out_overflow;
        obs_en    = en_cnt - e0;
        obs_clr   = clr_cnt - cl0;
        obs_ovl   = overlap_cnt - ov0;
        obs_enerr = en_err - er0;
    endtask

    task automatic end_job();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55; cmd_valid = 1'b1; cmd_len = 8'd4;
        #1;
        vectors++;
        if ({cmd_ready, busy, in_ready, out_valid, mac_enable, mac_clear} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 100000", {cmd_ready, busy, in_ready, out_valid, mac_enable, mac_clear});
        end
        vectors++;
        if ({mac_a, mac_b} !== 16'h0000) begin
            miscompares++; $display("FAIL reset_mac_ab: got %h want 0000", {mac_a, mac_b});
        end
        vectors++;
        if ({out_overflow, out_result} !== 17'd0) begin
            miscompares++; $display("FAIL reset_out: got %h want 0", {out_overflow, out_result});
        end
        in_valid = 1'b0; cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({cmd_ready, busy} !== 2'b10) begin
            miscompares++; $display("FAIL reset_release_idle: got %b want 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_basic();
        ja[0] = 8'd2; jb[0] = 8'd3; ja[1] = 8'd4; jb[1] = 8'd5; ja[2] = 8'd1; jb[2] = 8'd7;
        run_job(3, 0, 1'b0);
        vectors++;
        if (obs_res !== 16'h0021) begin miscompares++; $display("FAIL basic_result: got %h want 0021", obs_res); end
        vectors++;
        if (obs_ovf !== 1'b0) begin miscompares++; $display("FAIL basic_ovf: got %b want 0", obs_ovf); end
        vectors++;
        if (obs_lat !== 7) begin miscompares++; $display("FAIL basic_latency: got %0d want 7", obs_lat); end
        vectors++;
        if (obs_en !== 3 || obs_clr !== 1) begin
            miscompares++; $display("FAIL basic_pulses: got en=%0d clr=%0d want en=3 clr=1", obs_en, obs_clr);
        end
        end_job();
    endtask

    task automatic test_gaps();
        ja[0] = 8'd2; jb[0] = 8'd3; ja[1] = 8'd4; jb[1] = 8'd5; ja[2] = 8'd1; jb[2] = 8'd7;
        run_job(3, 2, 1'b0);
        vectors++;
        if (obs_res !== 16'h0021) begin miscompares++; $display("FAIL gaps_result: got %h want 0021", obs_res); end
        vectors++;
        if (obs_en !== 3 || obs_enerr !== 0 || obs_ovl !== 0) begin
            miscompares++;
            $display("FAIL gaps_enable: got en=%0d misaligned=%0d overlap=%0d want 3/0/0", obs_en, obs_enerr, obs_ovl);
        end
        vectors++;
        if (obs_lat !== last_fire - c0 + PIPE_LAT + 2) begin
            miscompares++; $display("FAIL gaps_latency: got %0d want %0d", obs_lat, last_fire - c0 + PIPE_LAT + 2);
        end
        end_job();
    endtask

    task automatic test_overflow();
        ja[0] = 8'd255; jb[0] = 8'd255; ja[1] = 8'd255; jb[1] = 8'd255;
        run_job(2, 0, 1'b0);
        vectors++;
        if (obs_res !== 16'hFC02) begin miscompares++; $display("FAIL ovf_result: got %h want fc02", obs_res); end
        vectors++;
        if (obs_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", obs_ovf); end
        end_job();
    endtask

    task automatic test_len0();
        run_job(0, 0, 1'b0);
        vectors++;
        if (obs_res !== 16'h0000 || obs_ovf !== 1'b0) begin
            miscompares++; $display("FAIL len0_result: got %h/%b want 0000/0", obs_res, obs_ovf);
        end
        vectors++;
        if (obs_lat !== 4) begin miscompares++; $display("FAIL len0_latency: got %0d want 4", obs_lat); end
        vectors++;
        if (obs_clr !== 1 || obs_en !== 0) begin
            miscompares++; $display("FAIL len0_pulses: got clr=%0d en=%0d want 1/0", obs_clr, obs_en);
        end
        end_job();
    endtask

    task automatic test_hold();
        logic [15:0] exp_res;
        ja[0] = 8'd17; jb[0] = 8'd19; ja[1] = 8'd100; jb[1] = 8'd3;
        exp_res = 16'(ref_sum(2));
        run_job(2, 0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1'b1; in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
            #1;
            vectors++;
            if ({out_valid, cmd_ready, in_ready} !== 3'b100 || out_result !== exp_res || out_overflow !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_stable: got v/cr/ir=%b res=%h ovf=%b want 100 %h 0",
                         {out_valid, cmd_ready, in_ready}, out_result, out_overflow, exp_res);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0; in_valid = 1'b0;
        end_job();
        vectors++;
        if ({out_valid, cmd_ready, busy} !== 3'b010) begin
            miscompares++; $display("FAIL hold_release: got %b want 010", {out_valid, cmd_ready, busy});
        end
    endtask

    task automatic test_reset_mid();
        int tmo;
        cmd_valid = 1'b1; cmd_len = 8'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
        tmo = 0;
        while (!in_ready && tmo < 20) begin @(posedge clk); #1; tmo++; end
        vectors++;
        if (tmo >= 20) begin miscompares++; $display("FAIL rstmid_stream_entry: got timeout want in_ready"); end
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        vectors++;
        if ({cmd_ready, busy, in_ready, out_valid, mac_enable, mac_clear} !== 6'b100000 || mac_a !== 8'd0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got %b mac_a=%h want 100000 00",
                     {cmd_ready, busy, in_ready, out_valid, mac_enable, mac_clear}, mac_a);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        ja[0] = 8'd3; jb[0] = 8'd3;
        run_job(1, 0, 1'b0);
        vectors++;
        if (obs_res !== 16'h0009 || obs_ovf !== 1'b0 || obs_lat !== 5) begin
            miscompares++;
            $display("FAIL rstmid_next_job: got %h/%b lat=%0d want 0009/0 lat=5", obs_res, obs_ovf, obs_lat);
        end
        end_job();
    endtask

    task automatic test_random();
        int len, s, exp_lat;
        for (int j = 0; j < 25; j++) begin
            len = ($urandom_range(3, 0) == 0) ? int'($urandom_range(70, 30)) : int'($urandom_range(12, 0));
            for (int i = 0; i < len; i++) begin
                ja[i] = 8'($urandom); jb[i] = 8'($urandom);
            end
            s = ref_sum(len);
            run_job(len, 3, 1'b1);
            exp_lat = (len == 0) ? 4 : last_fire - c0 + PIPE_LAT + 2;
            vectors++;
            if (obs_res !== 16'(s) || obs_ovf !== (s > 65535)) begin
                miscompares++;
                $display("FAIL rand_result job%0d len=%0d: got %h/%b want %h/%b", j, len, obs_res, obs_ovf, 16'(s), (s > 65535));
            end
            vectors++;
            if (obs_lat !== exp_lat || obs_tmo !== 1'b0) begin
                miscompares++; $display("FAIL rand_latency job%0d: got %0d tmo=%b want %0d", j, obs_lat, obs_tmo, exp_lat);
            end
            vectors++;
            if (obs_en !== len || obs_clr !== 1 || obs_ovl !== 0 || obs_enerr !== 0) begin
                miscompares++;
                $display("FAIL rand_pulses job%0d: got en=%0d clr=%0d ovl=%0d mis=%0d want %0d/1/0/0",
                         j, obs_en, obs_clr, obs_ovl, obs_enerr, len);
            end
            repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
            end_job();
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_len = '0; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_len0();
        test_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion want finish before 900000");
        $fatal(1, "watchdog expired");
    end

endmodule
